spi_regfile_ctrl: RTL and testbench

Parametrised SPI target (mode 0, MSB first) that owns a bank of N_RW flip-flop-based read/write control registers and exposes N_RO externally driven read-only status registers.
It is the next-generation replacement for the fixed 3-RW/56-RO front end.
It adds explicit command framing with cs_n, burst auto-increment for both read and write, per-register write strobes, and snapshot-safe readback.
It sits between the chip pads (sclk/cs_n/mosi/miso) and the core's control/status nets.

---
 rtl/spi_regfile_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_regfile_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_ctrl.sv
// SPI mode-0 target fronting a bank of RW control flops and externally driven RO status words.
// Frames are {rw_bit, start_addr} followed by auto-incrementing data words, all MSB first.
module spi_regfile_ctrl #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 7,
  parameter int                 N_RW     = 3,
  parameter int                 N_RO     = 56,
  parameter logic [DATA_W-1:0]  RW_RESET = '0
) (
  input  logic                   sclk,
  input  logic                   rstn,
  input  logic                   cs_n,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [N_RO*DATA_W-1:0] ro_data,
  output logic [N_RW*DATA_W-1:0] rw_data,
  output logic [N_RW-1:0]        wr_strobe,
  output logic [ADDR_W-1:0]      wr_addr
);

  localparam int CMD_BITS = ADDR_W + 1;
  localparam int MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS);
  // Only the bits preceding the word's last bit need storing; mosi supplies the last one.
  localparam int SH_W     = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;

  typedef enum logic {ST_CMD, ST_DATA} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [SH_W-1:0]     shift_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                dir_q;
  logic [DATA_W-1:0]   rd_buf_q;
  logic [DATA_W-1:0]   rw_q [N_RW];

  logic                cmd_done;
  logic                word_done;
  logic [ADDR_W:0]     cmd_in;
  logic [DATA_W-1:0]   word_in;
  logic [ADDR_W-1:0]   rd_sel;
  logic [DATA_W-1:0]   rd_word;
  logic [N_RW-1:0]     wr_hit;

  assign cmd_done  = (state_q == ST_CMD)  && (bit_cnt_q == CNT_W'(ADDR_W));
  assign word_done = (state_q == ST_DATA) && (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign cmd_in    = {shift_q[ADDR_W-1:0], mosi};
  assign word_in   = {shift_q[DATA_W-2:0], mosi};

  // Read buffer source: the start address at command end, otherwise the next address.
  assign rd_sel = cmd_done ? cmd_in[ADDR_W-1:0] : addr_q + ADDR_W'(1);

  // NOTE: every variable driven in always_comb gets a default first so no path infers a latch.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (rd_sel == ADDR_W'(k + 1)) rd_word = rw_q[k];
    end
    for (int k = 0; k < N_RO; k++) begin
      if (rd_sel == ADDR_W'(N_RW + 1 + k)) rd_word = ro_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int k = 0; k < N_RW; k++) begin
      wr_hit[k] = word_done && dir_q && (addr_q == ADDR_W'(k + 1));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CMD:  if (cmd_done) state_d = ST_DATA;
      ST_DATA: state_d = ST_DATA;
      default: state_d = ST_CMD;
    endcase
  end

  // Frame state: rstn clears it, and cs_n high clears it too without touching register contents.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or negedge rstn or posedge cs_n) begin
    if (!rstn) begin
      state_q   <= ST_CMD;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_strobe <= '0;
    end else if (cs_n) begin
      state_q   <= ST_CMD;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_strobe <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= {shift_q[SH_W-2:0], mosi};
      wr_strobe <= wr_hit;
      if (cmd_done || word_done) bit_cnt_q <= '0;
      else                       bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // Address, direction, readback snapshot and register contents survive cs_n; only rstn clears them.
  // NOTE: the RW bank is discrete flops rather than RAM, so it can and does take the reset value.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      addr_q   <= '0;
      dir_q    <= 1'b0;
      rd_buf_q <= '0;
      wr_addr  <= '0;
      for (int k = 0; k < N_RW; k++) rw_q[k] <= RW_RESET;
    end else begin
      if (cmd_done) begin
        addr_q   <= cmd_in[ADDR_W-1:0];
        dir_q    <= cmd_in[ADDR_W];
        rd_buf_q <= rd_word;
      end else if (word_done) begin
        addr_q   <= addr_q + ADDR_W'(1);
        rd_buf_q <= rd_word;
      end
      for (int k = 0; k < N_RW; k++) begin
        if (wr_hit[k]) rw_q[k] <= word_in;
      end
      if (|wr_hit) wr_addr <= addr_q;
    end
  end

  // miso launches on the falling edge so the master can sample it on the following rising edge.
  always_ff @(negedge sclk or negedge rstn or posedge cs_n) begin
    if (!rstn) begin
      miso <= 1'b0;
    end else if (cs_n) begin
      miso <= 1'b0;
    end else if (state_q == ST_DATA && !dir_q) begin
      miso <= rd_buf_q[CNT_W'(DATA_W - 1) - bit_cnt_q];
    end else begin
      miso <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_RW; k++) begin : g_rw_out
    assign rw_data[k*DATA_W +: DATA_W] = rw_q[k];
  end

endmodule

// File: tb/tb_spi_regfile_ctrl.sv
// Directed bench for spi_regfile_ctrl: a register-map model drives per-cycle expectations,
// and literal checks after each frame pin the model to hand-computed values.
module tb_spi_regfile_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 7;
  localparam int NRW = 3;
  localparam int NRO = 56;

  logic                sclk = 1'b0;
  logic                rstn;
  logic                cs_n;
  logic                mosi;
  logic                miso;
  logic [NRO*DW-1:0]   ro_data;
  logic [NRW*DW-1:0]   rw_data;
  logic [NRW-1:0]      wr_strobe;
  logic [AW-1:0]       wr_addr;

  spi_regfile_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .N_RW(NRW), .N_RO(NRO), .RW_RESET(8'h00)
  ) dut (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .ro_data(ro_data), .rw_data(rw_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 sclk = ~sclk;

  // Register-map model
  logic [7:0] ro_mem [NRO];
  logic [7:0] model_rw [1:3];
  logic [2:0] exp_strobe;
  logic [6:0] exp_wr_addr;
  logic       exp_miso;
  bit         chk_en;
  int         n_total;
  int         n_bad;
  logic [7:0] rd_cap  [8];
  logic [7:0] mdl_cap [8];

  always_comb begin
    ro_data = '0;
    for (int k = 0; k < NRO; k++) ro_data[k*DW +: DW] = ro_mem[k];
  end

  function automatic logic [7:0] model_read(input int a);
    if (a >= 1 && a <= NRW)       return model_rw[a];
    if (a > NRW && a <= NRW + NRO) return ro_mem[a - NRW - 1];
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, after each rising edge settles.
  initial begin
    forever begin
      @(posedge sclk);
      #2;
      if (chk_en) begin
        check("miso",      miso,      exp_miso);
        check("wr_strobe", wr_strobe, exp_strobe);
        check("wr_addr",   wr_addr,   exp_wr_addr);
        check("rw_data",   rw_data,   {model_rw[3], model_rw[2], model_rw[1]});
      end
    end
  end

  // One frame: command byte then nbits data bits (wdata sent MSB first).
  // glitch_bit flips RO slice 0 before that data bit; rst_bit pulses rstn instead of that data bit.
  task automatic frame(input logic [7:0] cmd, input int nbits, input logic [31:0] wdata,
                       input int glitch_bit, input int rst_bit);
    int         a;
    bit         wr;
    logic [7:0] byte_v;
    byte_v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge sclk); #1;
      if (i == 0) cs_n = 1'b0;
      mosi       = cmd[7-i];
      exp_miso   = 1'b0;
      exp_strobe = '0;
      @(posedge sclk); #1;
    end
    wr = cmd[7];
    a  = int'(cmd[6:0]);
    for (int j = 0; j < nbits; j++) begin
      int w;
      int b;
      w = j / 8;
      b = j % 8;
      @(negedge sclk); #1;
      if (j == rst_bit) begin
        rstn = 1'b0;
        for (int r = 1; r <= NRW; r++) model_rw[r] = 8'h00;
        exp_wr_addr = '0;
        exp_strobe  = '0;
        exp_miso    = 1'b0;
        @(negedge sclk); #1;
        cs_n = 1'b1;
        mosi = 1'b0;
        @(negedge sclk); #1;
        rstn = 1'b1;
        return;
      end
      if (b == 0) begin
        byte_v     = wr ? 8'h00 : model_read(a);
        mdl_cap[w] = byte_v;
      end
      if (j == glitch_bit) ro_mem[0] = ~ro_mem[0];
      mosi       = wdata[31-j];
      exp_miso   = byte_v[7-b];
      exp_strobe = '0;
      if (b == 7) begin
        if (wr && a >= 1 && a <= NRW) begin
          model_rw[a] = wdata[31-8*w -: 8];
          exp_strobe  = 3'(1 << (a - 1));
          exp_wr_addr = 7'(a);
        end
        a = (a + 1) % 128;
      end
      @(posedge sclk); #1;
      rd_cap[w][7-b] = miso;
    end
    @(negedge sclk); #1;
    cs_n       = 1'b1;
    mosi       = 1'b0;
    exp_miso   = 1'b0;
    exp_strobe = '0;
    @(negedge sclk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    chk_en  = 1'b0;
    rstn    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    for (int k = 0; k < NRO; k++) ro_mem[k] = 8'h00;
    ro_mem[0]  = 8'h5C;
    ro_mem[1]  = 8'hC3;
    ro_mem[55] = 8'h77;
    for (int r = 1; r <= NRW; r++) model_rw[r] = 8'h00;
    exp_strobe  = '0;
    exp_wr_addr = '0;
    exp_miso    = 1'b0;

    repeat (2) @(posedge sclk);
    #3;
    chk_en = 1'b1;
    check("reset_rw_data", rw_data, 24'h000000);
    check("reset_miso",    miso,    1'b0);
    check("reset_wr_addr", wr_addr, 7'd0);
    check("reset_strobe",  wr_strobe, 3'b000);
    @(negedge sclk); #1;
    rstn = 1'b1;

    // Single write to address 1
    frame(8'h81, 8, 32'hA5000000, -1, -1);
    check("t1_rw_data", rw_data, 24'h0000A5);
    check("t1_wr_addr", wr_addr, 7'd1);

    // Burst write across the end of the RW bank
    frame(8'h81, 32, 32'h11223344, -1, -1);
    check("t2_rw_data", rw_data, 24'h332211);
    check("t2_wr_addr", wr_addr, 7'd3);

    // Burst read RW -> RO
    frame(8'h03, 24, 32'h0, -1, -1);
    check("t3_byte0", rd_cap[0], 8'h33);
    check("t3_byte1", rd_cap[1], 8'h5C);
    check("t3_byte2", rd_cap[2], 8'hC3);
    check("t3_model_byte1", mdl_cap[1], 8'h5C);

    // Unmapped top address wrapping to address 0, then address 0 directly
    frame(8'h7F, 16, 32'h0, -1, -1);
    check("t4_unmapped127", rd_cap[0], 8'h00);
    check("t4_wrap_addr0",  rd_cap[1], 8'h00);
    frame(8'h00, 8, 32'h0, -1, -1);
    check("t4_addr0", rd_cap[0], 8'h00);

    // Last RO address, then first unmapped one
    frame(8'h3B, 16, 32'h0, -1, -1);
    check("ro_last",      rd_cap[0], 8'h77);
    check("ro_past_last", rd_cap[1], 8'h00);

    // Partial write word is discarded
    frame(8'h82, 5, 32'hFF000000, -1, -1);
    check("t5_rw_data", rw_data, 24'h332211);
    check("t5_wr_addr", wr_addr, 7'd3);
    frame(8'h02, 8, 32'h0, -1, -1);
    check("t5_read_reg2", rd_cap[0], 8'h22);

    // RO value changing mid-word must not tear the byte already loaded
    frame(8'h04, 8, 32'h0, 3, -1);
    check("snapshot", rd_cap[0], 8'h5C);
    ro_mem[0] = 8'h5C;

    // rstn mid-data of a write
    frame(8'h81, 8, 32'h3C000000, -1, 3);
    check("t6_rw_data", rw_data, 24'h000000);
    check("t6_miso",    miso,    1'b0);
    check("t6_wr_addr", wr_addr, 7'd0);
    frame(8'h83, 8, 32'h5A000000, -1, -1);
    frame(8'h03, 8, 32'h0, -1, -1);
    check("t6_readback", rd_cap[0], 8'h5A);
    check("t6_rw_after", rw_data, 24'h5A0000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
